// File: rtl/demux_reg.sv
// ---------------------------------------------------------------------------
// demux_reg -- registered 1-to-N demultiplexer
//
// Purpose:
//   Takes one BUS_SIZE word plus a binary channel index from a single
//   producer and steers it into one of CHANNELS single-entry holding slots.
//   Each slot has its own valid/ready handshake towards its consumer, so a
//   stalled consumer only ever blocks writes addressed to its own slot.
//
// Parameters:
//   CHANNELS  number of output channels (>= 2)
//   BUS_SIZE  word width in bits
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   producer presents a word
//   in_ready   out  word is accepted this cycle (combinational)
//   selector   in   binary channel index, valid values 0..CHANNELS-1
//   data_in    in   word to route
//   data_out   out  slot c in bits [BUS_SIZE*c +: BUS_SIZE]
//   out_valid  out  bit c: slot c holds an unconsumed word
//   out_ready  in   bit c: consumer c takes slot c this cycle
//   err_count  out  saturating count of cycles with in_valid and a bad
//                   selector (only when DEMUX_ERR_COUNT_EN is defined)
//
// Configuration macro:
//   DEMUX_ERR_COUNT_EN  adds the err_count port and its counter
// ---------------------------------------------------------------------------
module demux_reg #(
    parameter int CHANNELS = 4,
    parameter int BUS_SIZE = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS-1:0]          selector,
    input  logic [BUS_SIZE-1:0]          data_in,
    output logic [CHANNELS*BUS_SIZE-1:0] data_out,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ready
`ifdef DEMUX_ERR_COUNT_EN
    ,
    output logic [15:0]                  err_count
`endif
);

    localparam logic [CHANNELS-1:0] CHAN_LIMIT = CHANNELS'(CHANNELS);

    logic                         sel_ok_s;
    logic [CHANNELS-1:0]          hit_s;
    logic                         in_ready_s;
    logic [CHANNELS-1:0]          write_s;
    logic [CHANNELS-1:0]          valid_r;
    logic [CHANNELS*BUS_SIZE-1:0] data_r;

    // Selector decode: a one-hot hit vector that is all-zero for any
    // out-of-range or unknown index, so no slot is ever indexed out of range.
    // $isunknown folds to 0 in synthesis, where X/Z cannot exist.
    always_comb begin
        sel_ok_s = 1'b0;
        hit_s    = '0;
        if ($isunknown(selector)) begin
            sel_ok_s = 1'b0;
        end else begin
            sel_ok_s = (selector < CHAN_LIMIT);
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_ok_s && (selector == CHANNELS'(c))) begin
                hit_s[c] = 1'b1;
            end else begin
                hit_s[c] = 1'b0;
            end
        end
    end

    // Ready looks only at the addressed slot: it can take a word when empty
    // or when its current word is being drained in the same cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = sel_ok_s && (|(hit_s & (~valid_r | out_ready)));
        end
        write_s = hit_s & {CHANNELS{in_valid & in_ready_s}};
    end

    // Slot storage: a write wins over a drain of the same slot, which keeps
    // the slot full and gives one word per cycle per channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
            data_r  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (write_s[c]) begin
                    data_r[c*BUS_SIZE +: BUS_SIZE] <= data_in;
                    valid_r[c]                     <= 1'b1;
                end else if (valid_r[c] && out_ready[c]) begin
                    valid_r[c] <= 1'b0;
                end else begin
                    valid_r[c] <= valid_r[c];
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_r;
    assign data_out  = data_r;

`ifdef DEMUX_ERR_COUNT_EN
    logic [15:0] err_count_r;

    // Saturating count of cycles where the producer requests with a bad index.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_r <= 16'h0000;
        end else if (in_valid && !sel_ok_s && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'h0001;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`endif

endmodule

// File: tb/tb_demux_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_reg -- self-checking bench for demux_reg (CHANNELS=4, BUS_SIZE=32)
// Directed table of vectors, hand sequences for stream / unknown selector,
// then randomized traffic checked against a per-slot reference model.
// ---------------------------------------------------------------------------
module tb_demux_reg;

    localparam int CH = 4;
    localparam int BW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CH-1:0]     selector;
    logic [BW-1:0]     data_in;
    logic [CH*BW-1:0]  data_out;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready;
`ifdef DEMUX_ERR_COUNT_EN
    logic [15:0]       err_count;
    int                m_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: one holding register and one full flag per channel
    logic [BW-1:0] m_data [CH];
    logic          m_full [CH];

    demux_reg #(.CHANNELS(CH), .BUS_SIZE(BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .selector (selector),
        .data_in  (data_in),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef DEMUX_ERR_COUNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sel_valid(input logic [CH-1:0] s);
        if ($isunknown(s)) return 1'b0;
        return (int'(s) < CH);
    endfunction

    function automatic logic model_ready(input logic r, input logic [CH-1:0] s, input logic [CH-1:0] ordy);
        if (r || !sel_valid(s)) return 1'b0;
        return (!m_full[int'(s)]) || ordy[int'(s)];
    endfunction

    function automatic logic [CH-1:0] model_valid();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_full[c];
        return v;
    endfunction

    function automatic logic [CH*BW-1:0] model_dout();
        logic [CH*BW-1:0] d;
        for (int c = 0; c < CH; c++) d[c*BW +: BW] = m_data[c];
        return d;
    endfunction

    // one clock cycle: drive, check ready, clock, advance model, check outputs
    logic last_ir;
    task automatic step(input logic r, input logic iv, input logic [CH-1:0] s,
                        input logic [BW-1:0] d, input logic [CH-1:0] ordy);
        logic exp_ir;
        @(negedge clk);
        reset = r; in_valid = iv; selector = s; data_in = d; out_ready = ordy;
        #1;
        exp_ir = model_ready(r, s, ordy);
        last_ir = in_ready;
        check("in_ready", 128'(in_ready), 128'(exp_ir));
        @(posedge clk);
        if (r) begin
            for (int c = 0; c < CH; c++) begin m_full[c] = 1'b0; m_data[c] = '0; end
`ifdef DEMUX_ERR_COUNT_EN
            m_err = 0;
`endif
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (iv && exp_ir && (int'(s) == c)) begin
                    m_data[c] = d; m_full[c] = 1'b1;
                end else if (m_full[c] && ordy[c]) begin
                    m_full[c] = 1'b0;
                end
            end
`ifdef DEMUX_ERR_COUNT_EN
            if (iv && !sel_valid(s) && m_err < 65535) m_err++;
`endif
        end
        #1;
        check("out_valid", 128'(out_valid), 128'(model_valid()));
        check("data_out", 128'(data_out), 128'(model_dout()));
`ifdef DEMUX_ERR_COUNT_EN
        check("err_count", 128'(err_count), 128'(m_err));
`endif
    endtask

    typedef struct {
        logic          rst;
        logic          iv;
        logic [CH-1:0] sel;
        logic [BW-1:0] data;
        logic [CH-1:0] ordy;
        logic          exp_ir;
        logic [CH-1:0] exp_ov;
    } vec_t;

    vec_t tbl [14];
    int   accepts;

    initial begin
        for (int c = 0; c < CH; c++) begin m_full[c] = 1'b0; m_data[c] = '0; end
`ifdef DEMUX_ERR_COUNT_EN
        m_err = 0;
`endif
        reset = 1'b1; in_valid = 1'b0; selector = '0; data_in = '0; out_ready = '0;

        //            rst   iv    sel    data           ordy     ir    ov
        tbl[0]  = '{1'b1, 1'b1, 4'd0,  32'hDEAD_0000, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b1, 4'd0,  32'hDEAD_0001, 4'b0000, 1'b0, 4'b0000};
        tbl[2]  = '{1'b0, 1'b1, 4'd0,  32'hA5A5_0001, 4'b0000, 1'b1, 4'b0001};
        tbl[3]  = '{1'b0, 1'b1, 4'd1,  32'hA5A5_0002, 4'b0000, 1'b1, 4'b0011};
        tbl[4]  = '{1'b0, 1'b1, 4'd2,  32'hA5A5_0003, 4'b0000, 1'b1, 4'b0111};
        tbl[5]  = '{1'b0, 1'b1, 4'd3,  32'hA5A5_0004, 4'b0000, 1'b1, 4'b1111};
        tbl[6]  = '{1'b0, 1'b1, 4'd2,  32'hBBBB_0002, 4'b0000, 1'b0, 4'b1111};
        tbl[7]  = '{1'b0, 1'b1, 4'd2,  32'hBBBB_0002, 4'b0100, 1'b1, 4'b1111};
        tbl[8]  = '{1'b0, 1'b0, 4'd0,  32'h0000_0000, 4'b0101, 1'b1, 4'b1010};
        tbl[9]  = '{1'b0, 1'b1, 4'd4,  32'hEEEE_0004, 4'b0000, 1'b0, 4'b1010};
        tbl[10] = '{1'b0, 1'b1, 4'd15, 32'hEEEE_000F, 4'b0000, 1'b0, 4'b1010};
        tbl[11] = '{1'b0, 1'b1, 4'd0,  32'hC000_0000, 4'b0000, 1'b1, 4'b1011};
        tbl[12] = '{1'b0, 1'b1, 4'd1,  32'hC000_0001, 4'b0010, 1'b1, 4'b1011};
        tbl[13] = '{1'b0, 1'b0, 4'd0,  32'h0000_0000, 4'b1011, 1'b1, 4'b0000};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].ordy);
            check($sformatf("tbl%0d_ready", i), 128'(last_ir), 128'(tbl[i].exp_ir));
            check($sformatf("tbl%0d_valid", i), 128'(out_valid), 128'(tbl[i].exp_ov));
            if (i == 5) check("route_data", 128'(data_out),
                              {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001});
            if (i == 6) check("bp_hold", 128'(data_out[95:64]), 128'(32'hA5A5_0003));
            if (i == 7) check("bp_load", 128'(data_out[95:64]), 128'(32'hBBBB_0002));
`ifdef DEMUX_ERR_COUNT_EN
            if (i == 10) check("err_two", 128'(err_count), 128'(16'd2));
`endif
        end

        // unknown selector: model decides from the value actually driven
        step(1'b0, 1'b1, 4'bxxxx, 32'h1234_5678, 4'b0000);

        // stream of 8 back-to-back words into channel 1 with its consumer ready
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'd1, 32'h5000_0000 + 32'(i), 4'b0010);
            if (last_ir) accepts++;
            check("stream_word", 128'(data_out[63:32]), 128'(32'h5000_0000 + 32'(i)));
            check("stream_valid", 128'(out_valid[1]), 128'(1'b1));
        end
        check("stream_accepts", 128'(accepts), 128'(8));
        step(1'b0, 1'b0, 4'd1, 32'h0, 4'b0010);
        check("stream_drained", 128'(out_valid[1]), 128'(1'b0));

        // randomized traffic, occasional resets and bad selectors
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 CH'($urandom_range(0, 5)),
                 $urandom(),
                 CH'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
